// File: rtl/alu_ex.sv
// Execute-stage ALU with valid/ready on both sides; shifts run 1 bit per cycle.
// Define ALU_FAST_SHIFT_EN to swap in a single-cycle barrel shifter (SHIFT state removed).
//   state | meaning
//   IDLE  | empty, ready for an operation
//   SHIFT | iterative shift in progress (not present with ALU_FAST_SHIFT_EN)
//   DONE  | result held on result_out/cmp_out until out_ready
module alu_ex #(
    parameter int data_width  = 32,
    parameter int ALUop_width = 4,
    parameter int shamt_width = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ALUop_width-1:0] ALUop_in,
    input  logic [data_width-1:0]  op_a,
    input  logic [data_width-1:0]  op_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [data_width-1:0]  result_out,
    output logic                   cmp_out
);

    localparam logic [ALUop_width-1:0] ALU_add = ALUop_width'(0);
    localparam logic [ALUop_width-1:0] ALU_sub = ALUop_width'(1);
    localparam logic [ALUop_width-1:0] ALU_and = ALUop_width'(2);
    localparam logic [ALUop_width-1:0] ALU_or  = ALUop_width'(3);
    localparam logic [ALUop_width-1:0] ALU_xor = ALUop_width'(4);
    localparam logic [ALUop_width-1:0] ALU_sll = ALUop_width'(5);
    localparam logic [ALUop_width-1:0] ALU_srl = ALUop_width'(6);
    localparam logic [ALUop_width-1:0] ALU_sra = ALUop_width'(7);
    localparam logic [ALUop_width-1:0] ALU_eq  = ALUop_width'(8);
    localparam logic [ALUop_width-1:0] ALU_ne  = ALUop_width'(9);

`ifdef ALU_FAST_SHIFT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1, SHIFT = 2'd2} state_t;
`endif

    state_t                  state_q, state_d;
    logic [data_width-1:0]   result_q, result_d;
    logic                    cmp_q, cmp_d;
    logic [shamt_width-1:0]  shamt;
    logic                    accept;
`ifndef ALU_FAST_SHIFT_EN
    logic [shamt_width-1:0]  count_q, count_d;
    logic [ALUop_width-1:0]  op_q, op_d;
`endif

    assign shamt      = op_b[shamt_width-1:0];
    assign in_ready   = rst_n && !flush &&
                        ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state_q == DONE);
    assign result_out = result_q;
    assign cmp_out    = cmp_q;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cmp_d    = cmp_q;
`ifndef ALU_FAST_SHIFT_EN
        count_d  = count_q;
        op_d     = op_q;
`endif
        if (flush) begin
            state_d = IDLE;
            cmp_d   = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            count_d = '0;
`endif
        end else begin
            case (state_q)
                DONE: if (out_ready) state_d = IDLE;
`ifndef ALU_FAST_SHIFT_EN
                SHIFT: begin
                    case (op_q)
                        ALU_sll: result_d = {result_q[data_width-2:0], 1'b0};
                        ALU_srl: result_d = {1'b0, result_q[data_width-1:1]};
                        ALU_sra: result_d = {result_q[data_width-1], result_q[data_width-1:1]};
                        default: result_d = result_q;
                    endcase
                    count_d = count_q - shamt_width'(1);
                    if (count_q == shamt_width'(1)) state_d = DONE;
                end
`endif
                default: state_d = state_q;
            endcase

            // Accept overrides the DONE->IDLE exit so back-to-back ops have no bubble.
            if (accept) begin
                state_d = DONE;
                cmp_d   = 1'b0;
                case (ALUop_in)
                    ALU_add: result_d = op_a + op_b;
                    ALU_sub: result_d = op_a - op_b;
                    ALU_and: result_d = op_a & op_b;
                    ALU_or:  result_d = op_a | op_b;
                    ALU_xor: result_d = op_a ^ op_b;
                    ALU_eq: begin
                        cmp_d    = (op_a == op_b);
                        result_d = {{(data_width-1){1'b0}}, (op_a == op_b)};
                    end
                    ALU_ne: begin
                        cmp_d    = (op_a != op_b);
                        result_d = {{(data_width-1){1'b0}}, (op_a != op_b)};
                    end
`ifdef ALU_FAST_SHIFT_EN
                    ALU_sll: result_d = op_a << shamt;
                    ALU_srl: result_d = op_a >> shamt;
                    ALU_sra: result_d = $signed(op_a) >>> shamt;
`else
                    ALU_sll, ALU_srl, ALU_sra: begin
                        result_d = op_a;
                        count_d  = shamt;
                        op_d     = ALUop_in;
                        if (shamt != '0) state_d = SHIFT;
                    end
`endif
                    default: result_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            cmp_q    <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            count_q  <= '0;
            op_q     <= ALU_add;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cmp_q    <= cmp_d;
`ifndef ALU_FAST_SHIFT_EN
            count_q  <= count_d;
            op_q     <= op_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_ex.sv
// Directed-vector bench for alu_ex; expected values are hand-computed constants.
module tb_alu_ex;

    localparam logic [3:0] ALU_add = 4'd0;
    localparam logic [3:0] ALU_sub = 4'd1;
    localparam logic [3:0] ALU_or  = 4'd3;
    localparam logic [3:0] ALU_xor = 4'd4;
    localparam logic [3:0] ALU_sll = 4'd5;
    localparam logic [3:0] ALU_srl = 4'd6;
    localparam logic [3:0] ALU_sra = 4'd7;
    localparam logic [3:0] ALU_eq  = 4'd8;
    localparam logic [3:0] ALU_ne  = 4'd9;
`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, cmp_out;
    logic [3:0]  ALUop_in;
    logic [31:0] op_a, op_b, result_out;

    int n_vec = 0;
    int n_err = 0;

    alu_ex dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUop_in   (ALUop_in),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_out (result_out),
        .cmp_out    (cmp_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive an op and let one rising edge pass; returns at the following negedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        ALUop_in = op;
        op_a     = a;
        op_b     = b;
        @(negedge clk);
    endtask

    task automatic run_shift(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int   lat;
        logic busy_ready;
        out_ready = 1'b1;
        issue(op, a, b);
        in_valid   = 1'b0;
        lat        = 1;
        busy_ready = 1'b0;
        #1;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_ready = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result_out, exp);
        check({tag, " in_ready while shifting"}, {31'd0, busy_ready}, 32'd0);
        @(negedge clk);
        check({tag, " drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ALUop_in = '0; op_a = '0; op_b = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset in_ready", {31'd0, in_ready}, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", result_out, 32'd0);
        check("reset cmp", {31'd0, cmp_out}, 32'd0);
        rst_n = 1'b1;
        #1 check("post-reset in_ready", {31'd0, in_ready}, 32'd1);

        // add wrap, then back-to-back xor / eq / ne at full throughput
        @(negedge clk);
        out_ready = 1'b1;
        issue(ALU_add, 32'hFFFF_FFFF, 32'h0000_0002);
        check("add valid", {31'd0, out_valid}, 32'd1);
        check("add result", result_out, 32'h0000_0001);
        check("add cmp", {31'd0, cmp_out}, 32'd0);
        #1 check("b2b in_ready", {31'd0, in_ready}, 32'd1);
        issue(ALU_xor, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        check("xor valid", {31'd0, out_valid}, 32'd1);
        check("xor result", result_out, 32'hFFFF_FFFF);
        issue(ALU_eq, 32'd5, 32'd5);
        check("eq valid", {31'd0, out_valid}, 32'd1);
        check("eq result", result_out, 32'd1);
        check("eq cmp", {31'd0, cmp_out}, 32'd1);
        issue(ALU_ne, 32'd5, 32'd5);
        check("ne valid", {31'd0, out_valid}, 32'd1);
        check("ne result", result_out, 32'd0);
        check("ne cmp", {31'd0, cmp_out}, 32'd0);
        issue(ALU_sub, 32'd3, 32'd5);
        check("sub wrap", result_out, 32'hFFFF_FFFE);
        issue(4'd14, 32'h1234_5678, 32'h1);
        check("undef op result", result_out, 32'd0);
        check("undef op valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("idle after drain", {31'd0, out_valid}, 32'd0);

        // downstream stall with a pending op, then transfer + accept on the same edge
        out_ready = 1'b0;
        issue(ALU_or, 32'h0000_00F0, 32'h0000_000F);
        ALUop_in = ALU_add; op_a = 32'd10; op_b = 32'd20;
        for (int i = 0; i < 3; i++) begin
            check("stall valid", {31'd0, out_valid}, 32'd1);
            check("stall result", result_out, 32'h0000_00FF);
            #1 check("stall in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("post-stall valid", {31'd0, out_valid}, 32'd1);
        check("post-stall add", result_out, 32'd30);
        in_valid = 1'b0;
        @(negedge clk);
        check("post-stall drain", {31'd0, out_valid}, 32'd0);

        // flush while a compare result is held
        out_ready = 1'b0;
        issue(ALU_eq, 32'd7, 32'd7);
        in_valid = 1'b0;
        check("held eq cmp", {31'd0, cmp_out}, 32'd1);
        out_ready = 1'b1; in_valid = 1'b1; ALUop_in = ALU_add; op_a = 32'd1; op_b = 32'd1;
        flush = 1'b1;
        #1 check("flush blocks in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush out_valid", {31'd0, out_valid}, 32'd0);
        check("flush cmp cleared", {31'd0, cmp_out}, 32'd0);
        check("flush result kept", result_out, 32'd1);
        #1 check("flush in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // shifts
        run_shift("sra 4", ALU_sra, 32'h8000_0000, 32'd4, 32'hF800_0000, FAST ? 1 : 5);
        run_shift("sll 31", ALU_sll, 32'h0000_0001, 32'd31, 32'h8000_0000, FAST ? 1 : 32);
        run_shift("srl 31", ALU_srl, 32'h8000_0000, 32'd31, 32'h0000_0001, FAST ? 1 : 32);
        run_shift("sll 0", ALU_sll, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1);
        run_shift("srl 1", ALU_srl, 32'h8000_0001, 32'd1, 32'h4000_0000, FAST ? 1 : 2);

`ifndef ALU_FAST_SHIFT_EN
        // flush mid-shift: nothing may ever be presented
        issue(ALU_srl, 32'h8000_0000, 32'd20);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        in_valid = 1'b1; ALUop_in = ALU_add; op_a = 32'd2; op_b = 32'd2;
        flush = 1'b1;
        #1 check("mid-shift flush in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("mid-shift flush valid", {31'd0, out_valid}, 32'd0);
        #1 check("mid-shift flush idle", {31'd0, in_ready}, 32'd1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no result after flush", 32'(seen), 32'd0);

        // reset mid-shift
        issue(ALU_sll, 32'h0000_0001, 32'd31);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst mid-shift valid", {31'd0, out_valid}, 32'd0);
        check("rst mid-shift result", result_out, 32'd0);
        check("rst mid-shift cmp", {31'd0, cmp_out}, 32'd0);
        check("rst mid-shift in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst release in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check("rst release valid", {31'd0, out_valid}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_ex.md
Name: alu_ex

Overview:
- Execute-stage ALU. Sits directly downstream of the ALU-control decoder.
- Consumes the 4-bit ALUop from the decoder plus two 32-bit operands, and produces a registered result and a branch-compare flag for writeback and branch logic.
- Add, sub, logic and compare ops complete in one cycle.
- Shifts run on an iterative 1-bit-per-cycle shifter to save area.
- Valid/ready handshakes on both sides.

Parameters:
- data_width, 32, operand/result width
- ALUop_width, 4, width of ALUop_in; encodings are the shared ALU_* codes
- shamt_width, 5, shift-amount bits taken from op_b[shamt_width-1:0]

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of the in-flight/held operation
- in_valid  input  1  upstream operation valid
- in_ready  output  1  block can accept an operation this cycle
- ALUop_in  input  ALUop_width  operation code (ALU_add/sub/and/or/xor/sra/srl/sll/eq/ne)
- op_a  input  data_width  operand A
- op_b  input  data_width  operand B / shift amount
- out_valid  output  1  result_out/cmp_out valid
- out_ready  input  1  downstream accepts the result
- result_out  output  data_width  registered result
- cmp_out  output  1  compare flag (eq/ne ops), else 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; out_valid=0; result_out=0; cmp_out=0; internal shift count=0.
  - in_ready reflects IDLE, so it reads 1 once reset is released.
- States: IDLE, SHIFT, DONE.
- Handshakes:
  - Accept occurs when in_valid & in_ready at a clock edge; operands and ALUop are captured on that edge.
  - Output transfer occurs when out_valid & out_ready at an edge.
  - in_ready = (state==IDLE) | (state==DONE & out_ready). This allows back-to-back single-cycle ops at full throughput.
- Non-shift ops:
  - On accept, the result is computed and registered: state->DONE, out_valid=1 next cycle. Latency is 1 cycle.
  - add/sub: wrap modulo 2^data_width; no carry/overflow output.
  - and/or/xor: bitwise.
  - eq: cmp_out = (a==b); ne: cmp_out = (a!=b). In both cases result_out = {zeros, cmp_out}.
  - Any ALUop not in the ALU_* set, including the decoder default 0 if it is not ALU_add, gives result_out=0, cmp_out=0, latency 1.
- Shift ops (sll/srl/sra):
  - On accept, capture a and shamt = op_b[shamt_width-1:0].
  - shamt==0 -> DONE directly; result=a, latency 1.
  - Otherwise go to SHIFT. Each cycle, shift the working register by 1 and decrement the count. When the count reaches 0, go to DONE.
  - Total latency = shamt+1 cycles; shamt=31 -> 32 cycles.
  - sra replicates bit[data_width-1] on each step. srl/sll fill with 0.
  - in_ready=0 throughout SHIFT.
- DONE:
  - out_valid=1; result_out/cmp_out are held stable until the transfer.
  - On transfer with a simultaneous new accept, the new op is loaded in the same edge and there is no bubble.
  - On transfer with no new op -> IDLE, out_valid=0.
- flush (synchronous, highest priority after reset):
  - Next state=IDLE, out_valid=0, and any shift is abandoned.
  - A simultaneous in_valid is not accepted (in_ready is forced 0 while flush=1).
  - result_out retains its last value; cmp_out is cleared.
- Reset mid-shift: abort immediately to the reset values above.
- Downstream stall (out_ready=0 in DONE): hold all outputs indefinitely; in_ready=0.

Optional Feature:
- Macro ALU_FAST_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter. All ops take 1-cycle latency, the SHIFT state is not instantiated, and the block is fully pipelined at 1 op/cycle.
- Undefined: iterative shifter as described, latency shamt+1.
- Handshake rules are identical in both builds.

Test Plan:
- Reset release, then one accept of add a=0xFFFFFFFF, b=0x00000002 -> the cycle after accept: out_valid=1, result_out=0x00000001, cmp_out=0. Before reset release: in_ready=0, out_valid=0.
- Back-to-back with out_ready=1: xor 0xF0F0F0F0^0x0F0F0F0F, then eq 5,5, then ne 5,5 -> results 0xFFFFFFFF; 1 with cmp_out=1; 0 with cmp_out=0, on consecutive cycles with no bubble.
- sra a=0x80000000, b=4 -> out_valid after 5 cycles with result 0xF8000000. sll a=1, b=31 -> after 32 cycles, result 0x80000000. in_ready=0 during SHIFT.
- Hold out_ready=0 for 3 cycles after an or result -> result_out/out_valid stable for those 3 cycles and in_ready=0; transfer when out_ready=1.
- Assert flush during SHIFT (srl, b=20, flush at cycle 5) -> next cycle IDLE, out_valid=0, in_ready=1; no result is ever presented. Repeat with rst_n low mid-shift -> all outputs 0 immediately.
- With ALU_FAST_SHIFT_EN defined: srl 0x80000000 by 31 -> result 0x00000001 with latency 1.
